// File: rtl/ch_serializer_if.sv
// Stream interface of the channel serializer: snapshot inputs plus the serial word output.
interface ch_serializer_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
);
  logic                     enable;
  logic                     strobe;
  logic [SEL_W-1:0]         channels;
  logic [NUM_CH*DATA_W-1:0] din;
  logic [DATA_W-1:0]        dout;
  logic                     dout_valid;
  logic                     dout_ready;
  logic [SEL_W-1:0]         dout_sel;
  logic                     dout_first;
  logic                     dout_last;
  logic                     overrun;

  // Serializer side.
  modport master (
    input  enable, strobe, channels, din, dout_ready,
    output dout, dout_valid, dout_sel, dout_first, dout_last, overrun
  );

  // Environment side: strobe source and downstream sink.
  modport slave (
    output enable, strobe, channels, din, dout_ready,
    input  dout, dout_valid, dout_sel, dout_first, dout_last, overrun
  );
endinterface

// File: rtl/ch_serializer.sv
// Snapshots up to NUM_CH channel words on a strobe and streams the active ones
// lowest index first with first/last flags; flags strobes lost while busy.
module ch_serializer #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
) (
  input  logic           clk,
  input  logic           reset,
  ch_serializer_if.master bus
);

  localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state;
  logic [NUM_CH*DATA_W-1:0] snap;
  logic [SEL_W-1:0]         max_idx;

  logic             start_c;
  logic             xfer_c;
  logic             at_last_c;
  logic [SEL_W-1:0] clamp_c;
  logic [SEL_W-1:0] next_sel_c;

  assign start_c    = bus.enable && bus.strobe;
  assign xfer_c     = bus.dout_valid && bus.dout_ready;
  assign at_last_c  = (bus.dout_sel == max_idx);
  assign clamp_c    = (bus.channels > MAX_IDX) ? MAX_IDX : bus.channels;
  assign next_sel_c = bus.dout_sel + SEL_W'(1);

  // A frame starts from IDLE, or back-to-back on the last-word transfer edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      snap           <= '0;
      max_idx        <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_sel   <= '0;
      bus.dout_first <= 1'b0;
      bus.dout_last  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            state          <= SEND;
            snap           <= bus.din;
            max_idx        <= clamp_c;
            bus.dout       <= bus.din[DATA_W-1:0];
            bus.dout_valid <= 1'b1;
            bus.dout_sel   <= '0;
            bus.dout_first <= 1'b1;
            bus.dout_last  <= (clamp_c == '0);
          end
        end
        SEND: begin
          if (xfer_c && at_last_c) begin
            bus.dout_sel <= '0;
            if (start_c) begin
              snap           <= bus.din;
              max_idx        <= clamp_c;
              bus.dout       <= bus.din[DATA_W-1:0];
              bus.dout_valid <= 1'b1;
              bus.dout_first <= 1'b1;
              bus.dout_last  <= (clamp_c == '0);
            end else begin
              state          <= IDLE;
              bus.dout_valid <= 1'b0;
              bus.dout_first <= 1'b0;
              bus.dout_last  <= 1'b0;
            end
          end else begin
            // Strobe while the frame is still draining is lost.
            if (start_c) begin
              bus.overrun <= 1'b1;
            end
            if (xfer_c) begin
              bus.dout_sel   <= next_sel_c;
              bus.dout       <= snap[32'(next_sel_c) * DATA_W +: DATA_W];
              bus.dout_first <= 1'b0;
              bus.dout_last  <= (next_sel_c == max_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch_serializer.sv
// Directed bench for ch_serializer: default 8-channel instance plus a 4-channel clamp instance.
module tb_ch_serializer;

  logic clk;
  logic reset;

  int errors;
  int checks;

  ch_serializer_if #(.NUM_CH(8), .DATA_W(16), .SEL_W(3)) bus1 ();
  ch_serializer_if #(.NUM_CH(4), .DATA_W(16), .SEL_W(3)) bus2 ();

  ch_serializer #(.NUM_CH(8), .DATA_W(16), .SEL_W(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  ch_serializer #(.NUM_CH(4), .DATA_W(16), .SEL_W(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect1(input string tag, input logic v, input logic [2:0] sel,
                         input logic [15:0] d, input logic f, input logic l);
    check({tag, ".valid"}, 32'(bus1.dout_valid), 32'(v));
    if (v) begin
      check({tag, ".sel"},   32'(bus1.dout_sel),   32'(sel));
      check({tag, ".dout"},  32'(bus1.dout),       32'(d));
      check({tag, ".first"}, 32'(bus1.dout_first), 32'(f));
      check({tag, ".last"},  32'(bus1.dout_last),  32'(l));
    end else begin
      check({tag, ".first"}, 32'(bus1.dout_first), 32'(0));
      check({tag, ".last"},  32'(bus1.dout_last),  32'(0));
    end
  endtask

  task automatic set_din_base(input logic [15:0] base);
    for (int k = 0; k < 8; k++) bus1.din[k*16 +: 16] = base + 16'(k);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus1.strobe = 1'b0;
    bus2.strobe = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic strobe1(input logic [2:0] ch);
    bus1.channels = ch;
    bus1.enable   = 1'b1;
    bus1.strobe   = 1'b1;
    tick();
    bus1.strobe   = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus1.enable = 1'b0; bus1.strobe = 1'b0; bus1.channels = '0; bus1.dout_ready = 1'b1;
    bus2.enable = 1'b0; bus2.strobe = 1'b0; bus2.channels = '0; bus2.dout_ready = 1'b1;
    set_din_base(16'd1);
    for (int k = 0; k < 4; k++) bus2.din[k*16 +: 16] = 16'(k + 1);
    tick();
    tick();

    // Reset state
    check("rst.dout",    32'(bus1.dout),       32'(0));
    check("rst.valid",   32'(bus1.dout_valid), 32'(0));
    check("rst.sel",     32'(bus1.dout_sel),   32'(0));
    check("rst.first",   32'(bus1.dout_first), 32'(0));
    check("rst.last",    32'(bus1.dout_last),  32'(0));
    check("rst.overrun", 32'(bus1.overrun),    32'(0));
    reset = 1'b0;
    tick();

    // Two-channel frames, strobe every 64 clocks
    for (int r = 0; r < 2; r++) begin
      strobe1(3'd1);
      expect1("two.w0", 1'b1, 3'd0, 16'd1, 1'b1, 1'b0);
      tick();
      expect1("two.w1", 1'b1, 3'd1, 16'd2, 1'b0, 1'b1);
      tick();
      expect1("two.end", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      check("two.overrun", 32'(bus1.overrun), 32'(0));
      for (int i = 0; i < 61; i++) tick();
    end

    // Eight channels with ready toggling: each word held one extra cycle
    do_reset();
    strobe1(3'd7);
    for (int k = 0; k < 8; k++) begin
      expect1("tog.a", 1'b1, 3'(k), 16'(k + 1), k == 0, k == 7);
      bus1.dout_ready = 1'b0;
      tick();
      expect1("tog.b", 1'b1, 3'(k), 16'(k + 1), k == 0, k == 7);
      bus1.dout_ready = 1'b1;
      tick();
    end
    expect1("tog.end", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

    // Overrun: second strobe two cycles into a four-word frame
    do_reset();
    strobe1(3'd3);
    expect1("ovr.w0", 1'b1, 3'd0, 16'd1, 1'b1, 1'b0);
    tick();
    expect1("ovr.w1", 1'b1, 3'd1, 16'd2, 1'b0, 1'b0);
    check("ovr.pre", 32'(bus1.overrun), 32'(0));
    bus1.strobe = 1'b1;
    tick();
    bus1.strobe = 1'b0;
    expect1("ovr.w2", 1'b1, 3'd2, 16'd3, 1'b0, 1'b0);
    check("ovr.set", 32'(bus1.overrun), 32'(1));
    tick();
    expect1("ovr.w3", 1'b1, 3'd3, 16'd4, 1'b0, 1'b1);
    tick();
    expect1("ovr.end", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    expect1("ovr.quiet", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("ovr.sticky", 32'(bus1.overrun), 32'(1));

    // Back-to-back: din changes mid-frame, new strobe on the last-word edge
    do_reset();
    strobe1(3'd1);
    expect1("b2b.w0", 1'b1, 3'd0, 16'd1, 1'b1, 1'b0);
    set_din_base(16'h00A0);
    tick();
    expect1("b2b.w1", 1'b1, 3'd1, 16'd2, 1'b0, 1'b1);
    bus1.strobe = 1'b1;
    tick();
    bus1.strobe = 1'b0;
    expect1("b2b.w2", 1'b1, 3'd0, 16'h00A0, 1'b1, 1'b0);
    tick();
    expect1("b2b.w3", 1'b1, 3'd1, 16'h00A1, 1'b0, 1'b1);
    tick();
    expect1("b2b.end", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("b2b.overrun", 32'(bus1.overrun), 32'(0));

    // Clamp on the four-channel instance
    do_reset();
    bus2.channels = 3'd7;
    bus2.enable   = 1'b1;
    bus2.strobe   = 1'b1;
    tick();
    bus2.strobe   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("clamp.valid", 32'(bus2.dout_valid), 32'(1));
      check("clamp.sel",   32'(bus2.dout_sel),   32'(k));
      check("clamp.dout",  32'(bus2.dout),       32'(k + 1));
      check("clamp.last",  32'(bus2.dout_last),  32'(k == 3));
      tick();
    end
    check("clamp.end", 32'(bus2.dout_valid), 32'(0));

    // enable low: strobe ignored
    set_din_base(16'd1);
    bus1.enable = 1'b0;
    bus1.strobe = 1'b1;
    bus1.channels = 3'd2;
    tick();
    tick();
    bus1.strobe = 1'b0;
    expect1("dis.idle", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("dis.overrun", 32'(bus1.overrun), 32'(0));

    // Reset mid-frame at sel2, then a full frame
    strobe1(3'd7);
    tick();
    tick();
    expect1("mid.w2", 1'b1, 3'd2, 16'd3, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid.dout",  32'(bus1.dout),       32'(0));
    check("mid.valid", 32'(bus1.dout_valid), 32'(0));
    check("mid.sel",   32'(bus1.dout_sel),   32'(0));
    check("mid.first", 32'(bus1.dout_first), 32'(0));
    check("mid.last",  32'(bus1.dout_last),  32'(0));
    tick();
    check("mid.idle", 32'(bus1.dout_valid), 32'(0));
    strobe1(3'd7);
    for (int k = 0; k < 8; k++) begin
      expect1("mid.frame", 1'b1, 3'(k), 16'(k + 1), k == 0, k == 7);
      tick();
    end
    expect1("mid.end", 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("mid.overrun", 32'(bus1.overrun), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
